unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sequences fixed-latency multi-cycle accesses and returns data with a one-cycle ready pulse per port.
- Generates per-stage stall requests consumed by the hazard detection unit, which freezes the PC and pipeline registers.
- Sits between the IF/MEM stages and the memory macro.

Parameters:
MEM_LAT, 4, memory cycles per access (legal 1..15)
ADDR_W, 16, address width
DATA_W, 16, data width

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock, synchronous, active-low
i_req  input  1  instruction fetch request; held until i_rdy
i_addr  input  ADDR_W  fetch address
i_flush  input  1  branch/jump flush; discards the in-flight or pending fetch result
i_rdy  output  1  one-cycle pulse; i_data valid
i_data  output  DATA_W  registered fetched instruction
d_re  input  1  load request; held until d_rdy
d_we  input  1  store request; held until d_rdy
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_rdy  output  1  one-cycle pulse; load or store complete
d_rdata  output  DATA_W  registered load data
hlt  input  1  halt; blocks new grants
mem_en  output  1  memory access active
mem_we  output  1  memory write
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data; valid in the last access cycle
stall_if  output  1  IF must hold
stall_mem  output  1  MEM must hold

Behaviour:
- FSM states: IDLE, ACC_I, ACC_D. Down-counter cnt is 4 bits wide.
- Synchronous reset, also when asserted mid-access:
  - State goes to IDLE; cnt=0; in-flight access is dropped.
  - i_rdy, d_rdy, mem_en, mem_we = 0; i_data, d_rdata, mem_addr, mem_wdata = 0.
  - last_grant = I, so D wins the first tie.
- Data requests: d_req = d_re | d_we. If both d_re and d_we are high, the access is a write.
- IDLE grant rules:
  - If hlt=1, no grant.
  - Mask: a port whose rdy is high this cycle is treated as not requesting.
  - If only one port requests, grant it.
  - If both request, grant the port opposite last_grant.
  - At the grant edge: capture addr, wdata and we; load cnt=MEM_LAT-1; update last_grant; enter ACC_x.
- ACC_x:
  - mem_en=1. mem_addr, mem_we and mem_wdata are driven from the captured registers and held stable for all MEM_LAT cycles.
  - Decrement cnt each cycle.
  - At cnt==0: register mem_rdata into i_data (ACC_I) or d_rdata (ACC_D loads only; stores leave d_rdata unchanged).
  - At the same edge: set the matching rdy for the next cycle and return to IDLE.
- Outside ACC: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Latency: request seen in IDLE at cycle 0 → access cycles 1..MEM_LAT → rdy at cycle MEM_LAT+1.
  - With default MEM_LAT=4, rdy arrives at cycle 5.
  - The rdy cycle may itself be the grant cycle of the other port, so back-to-back accesses have no extra bubble.
- Requester inputs must stay stable until rdy. The requester deasserts or changes its request in the cycle after rdy.
- Flush:
  - i_flush during ACC_I: the access runs to completion (memory cannot abort), but i_rdy is suppressed and i_data is not updated.
  - i_flush in IDLE: a pending i_req is not granted that cycle.
  - i_flush has no effect on the data port.
- hlt: an in-flight access completes normally and its rdy is still issued; no new grants occur while hlt=1.
- Stall outputs (combinational):
  - stall_if = i_req & ~i_rdy & ~i_flush.
  - stall_mem = d_req & ~d_rdy.
- rdy pulses last exactly one cycle. i_rdy and d_rdy are never high together.

Test Plan:
- Single load: d_re=1, d_addr=0x0010, mem returns 0xBEEF in the last access cycle → mem_en high cycles 1–4, d_rdy pulse at cycle 5, d_rdata=0xBEEF, stall_mem high cycles 0–4.
- Store: d_we=1, d_addr=0x0020, d_wdata=0x1234 → mem_we=1 with addr/data stable for 4 cycles; d_rdy at cycle 5; d_rdata unchanged.
- Contention fairness:
  - Setup: i_req and d_re asserted together from reset.
  - D is granted first; d_rdy at cycle 5; I granted at cycle 5; i_rdy at cycle 10.
  - Repeated contention alternates grants.
- Flush mid-fetch: assert i_flush at cycle 2 of ACC_I → mem_en still held 4 cycles, no i_rdy pulse, i_data unchanged.
- Halt: hlt=1 during ACC_D with i_req pending → d_rdy issued; no further mem_en while hlt=1.
- Reset mid-access: rst_n=0 at cycle 3 of ACC_D → next cycle all outputs 0, state IDLE; after release, the held d_re restarts a full 4-cycle access.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported, fixed-latency memory between the IF and MEM stages.
// Grants alternate on contention; each access returns a one-cycle rdy pulse to its port.
module unified_mem_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic              i_rdy,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rdy,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              hlt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_I = 2'd1,
    ACC_D = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic              last_d;
  logic              flushed;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic d_req;
  logic i_req_m;
  logic d_req_m;
  logic grant_i;
  logic grant_d;
  logic done;

  // Handshake: a port raises its request with stable operands and holds them until
  // its rdy pulse; rdy is high for exactly one cycle with the data register valid,
  // and the requester may drop or change the request in the following cycle.
  assign d_req   = d_re | d_we;
  assign i_req_m = i_req & ~i_rdy & ~i_flush;
  assign d_req_m = d_req & ~d_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!hlt) begin
          // On a tie the port that did not win last time goes first.
          if (d_req_m && (!i_req_m || !last_d)) grant_d = 1'b1;
          else if (i_req_m)                     grant_i = 1'b1;
        end
        if (grant_d)      state_next = ACC_D;
        else if (grant_i) state_next = ACC_I;
      end
      ACC_I, ACC_D: begin
        if (cnt == 4'd0) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state != IDLE) begin
      mem_en    = 1'b1;
      mem_we    = we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
    end
  end

  assign stall_if  = i_req & ~i_rdy & ~i_flush;
  assign stall_mem = d_req & ~d_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      last_d  <= 1'b0;
      flushed <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      i_rdy   <= 1'b0;
      d_rdy   <= 1'b0;
      i_data  <= '0;
      d_rdata <= '0;
    end else begin
      i_rdy <= 1'b0;
      d_rdy <= 1'b0;
      if (grant_i || grant_d) begin
        cnt     <= CNT_INIT;
        last_d  <= grant_d;
        flushed <= 1'b0;
        we_q    <= grant_d & d_we;
        addr_q  <= grant_d ? d_addr : i_addr;
        wdata_q <= grant_d ? d_wdata : '0;
      end else if (state != IDLE) begin
        cnt <= done ? 4'd0 : cnt - 4'd1;
        // A flush anywhere in the fetch kills its result; the memory still finishes.
        if (state == ACC_I && i_flush) flushed <= 1'b1;
        if (done) begin
          if (state == ACC_I) begin
            if (!(flushed || i_flush)) begin
              i_data <= mem_rdata;
              i_rdy  <= 1'b1;
            end
          end else begin
            d_rdy <= 1'b1;
            if (!we_q) d_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule
